// File: rtl/deploy_controller.sv
// deploy_controller: elixir meter plus single-cursor deploy arbiter for the three unit slots.
// Latency: every output is registered and reflects the inputs sampled one Clk earlier.
// Backpressure: none; unaffordable, busy-slot or game-over requests are dropped silently.
module deploy_controller #(
  parameter int FIELD_XMIN   = 200,
  parameter int FIELD_XMAX   = 560,
  parameter int FIELD_YMIN   = 40,
  parameter int FIELD_YMAX   = 440,
  parameter int COST0        = 3,
  parameter int COST1        = 4,
  parameter int COST2        = 5,
  parameter int ELIXIR_MAX   = 10,
  parameter int ELIXIR_INIT  = 5,
  parameter int REGEN_FRAMES = 60
) (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       card_valid,
  input  logic [1:0] card_sel,
  input  logic       click,
  input  logic [9:0] MouseX,
  input  logic [9:0] MouseY,
  input  logic [2:0] unit_dead,
  input  logic       game_over,
  output logic [2:0] instate,
  output logic [2:0] deploy,
  output logic [2:0] idle,
  output logic [3:0] elixir,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PLACE} state_t;

  localparam logic [9:0] XMIN       = 10'(FIELD_XMIN);
  localparam logic [9:0] XMAX       = 10'(FIELD_XMAX);
  localparam logic [9:0] YMIN       = 10'(FIELD_YMIN);
  localparam logic [9:0] YMAX       = 10'(FIELD_YMAX);
  localparam logic [3:0] C0         = 4'(COST0);
  localparam logic [3:0] C1         = 4'(COST1);
  localparam logic [3:0] C2         = 4'(COST2);
  localparam logic [3:0] EMAX       = 4'(ELIXIR_MAX);
  localparam logic [3:0] EINIT      = 4'(ELIXIR_INIT);
  localparam logic [5:0] REGEN_LAST = 6'(REGEN_FRAMES - 1);

  state_t     state, state_nxt;
  logic [1:0] sel, sel_nxt;
  logic [2:0] active, active_nxt;
  logic [5:0] frame_cnt, frame_cnt_nxt;
  logic [3:0] elixir_nxt;
  logic [4:0] elix_sum;
  logic [2:0] instate_nxt, deploy_nxt, idle_nxt;
  logic       busy_nxt;
  logic       in_field, pick_ok, place_ok, spend, regen;

  // Card 3 is the cancel code; it maps to an unaffordable cost so it can never arm.
  function automatic logic [3:0] cost_of(input logic [1:0] s);
    case (s)
      2'd0:    cost_of = C0;
      2'd1:    cost_of = C1;
      2'd2:    cost_of = C2;
      default: cost_of = 4'hf;
    endcase
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] s);
    onehot = 3'b001 << s;
  endfunction

  assign in_field = (MouseX >= XMIN) && (MouseX <= XMAX) &&
                    (MouseY >= YMIN) && (MouseY <= YMAX);
  assign pick_ok  = card_valid && (card_sel != 2'd3) &&
                    ~|(active & onehot(card_sel)) && (elixir >= cost_of(card_sel));
  assign place_ok = click && in_field && (elixir >= cost_of(sel));

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      sel   <= 2'd0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    if (game_over) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_ok) begin
            state_nxt = S_ARMED;
            sel_nxt   = card_sel;
          end
        end
        S_ARMED: begin
          if (card_valid && card_sel == 2'd3) state_nxt = S_IDLE;
          else if (place_ok)                  state_nxt = S_PLACE;
          else if (pick_ok)                   sel_nxt   = card_sel;
        end
        S_PLACE: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Spend is committed on the edge that leaves PLACE, so it can coincide with a regen tick.
  always_comb begin
    spend         = (state == S_PLACE) && !game_over && (elixir >= cost_of(sel));
    regen         = frame_tick && !game_over && (frame_cnt == REGEN_LAST);
    frame_cnt_nxt = frame_cnt;
    if (frame_tick && !game_over) frame_cnt_nxt = regen ? 6'd0 : frame_cnt + 6'd1;
    idle_nxt      = active & (game_over ? 3'b111 : unit_dead);
    active_nxt    = (active & ~idle_nxt) | (spend ? onehot(sel) : 3'b000);
    elix_sum      = {1'b0, elixir} - (spend ? {1'b0, cost_of(sel)} : 5'd0) + {4'd0, regen};
    elixir_nxt    = (elix_sum > {1'b0, EMAX}) ? EMAX : elix_sum[3:0];
    instate_nxt   = (state_nxt == S_ARMED) ? onehot(sel_nxt) : 3'b000;
    deploy_nxt    = (state_nxt == S_PLACE) ? onehot(sel_nxt) : 3'b000;
    busy_nxt      = (state_nxt == S_ARMED);
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      active    <= 3'b000;
      frame_cnt <= 6'd0;
      elixir    <= EINIT;
      instate   <= 3'b000;
      deploy    <= 3'b000;
      idle      <= 3'b111;
      busy      <= 1'b0;
    end else begin
      active    <= active_nxt;
      frame_cnt <= frame_cnt_nxt;
      elixir    <= elixir_nxt;
      instate   <= instate_nxt;
      deploy    <= deploy_nxt;
      idle      <= idle_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_deploy_controller.sv
// Bench for deploy_controller: directed vector table, hand-written corner sequences,
// then randomized traffic against an integer-arithmetic reference model.
`timescale 1ns/1ps
module tb_deploy_controller;

  logic       Clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       frame_tick = 1'b0, card_valid = 1'b0, click = 1'b0, game_over = 1'b0;
  logic [1:0] card_sel = 2'd0;
  logic [9:0] MouseX = 10'd0, MouseY = 10'd0;
  logic [2:0] unit_dead = 3'b000;
  logic [2:0] instate, deploy, idle;
  logic [3:0] elixir;
  logic       busy;

  always #5 Clk = ~Clk;

  deploy_controller dut (
    .Clk(Clk), .reset_n(reset_n), .frame_tick(frame_tick), .card_valid(card_valid),
    .card_sel(card_sel), .click(click), .MouseX(MouseX), .MouseY(MouseY),
    .unit_dead(unit_dead), .game_over(game_over), .instate(instate), .deploy(deploy),
    .idle(idle), .elixir(elixir), .busy(busy)
  );

  int n_vec = 0, n_bad = 0;

  typedef struct {
    logic       cv;
    logic [1:0] cs;
    logic       ck;
    int         mx;
    int         my;
    logic [2:0] dd;
    logic [2:0] e_in;
    logic [2:0] e_dp;
    logic [2:0] e_id;
    logic [3:0] e_el;
    logic       e_bz;
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string name, input logic [2:0] e_in, input logic [2:0] e_dp,
                       input logic [2:0] e_id, input logic [3:0] e_el, input logic e_bz);
    n_vec++;
    if (instate !== e_in || deploy !== e_dp || idle !== e_id || elixir !== e_el || busy !== e_bz) begin
      n_bad++;
      $display("FAIL %s: got instate=%b deploy=%b idle=%b elixir=%0d busy=%b, want instate=%b deploy=%b idle=%b elixir=%0d busy=%b",
               name, instate, deploy, idle, elixir, busy, e_in, e_dp, e_id, e_el, e_bz);
    end
  endtask

  task automatic drive(input logic cv, input logic [1:0] cs, input logic ck, input int mx,
                       input int my, input logic [2:0] dd, input logic g, input logic tk);
    card_valid = cv; card_sel = cs; click = ck; MouseX = 10'(mx); MouseY = 10'(my);
    unit_dead = dd; game_over = g; frame_tick = tk;
  endtask

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic cyc(input string name, input logic cv, input logic [1:0] cs, input logic ck,
                     input int mx, input int my, input logic [2:0] dd, input logic g, input logic tk,
                     input logic [2:0] e_in, input logic [2:0] e_dp, input logic [2:0] e_id,
                     input logic [3:0] e_el, input logic e_bz);
    drive(cv, cs, ck, mx, my, dd, g, tk);
    step();
    check(name, e_in, e_dp, e_id, e_el, e_bz);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 3'b000, 0, 1);
      step();
    end
  endtask

  // Asserted away from any edge; outputs must flip without a clock.
  task automatic do_reset(input string name);
    #2;
    drive(0, 0, 0, 0, 0, 3'b000, 0, 0);
    reset_n = 1'b0;
    #1;
    check(name, 3'b000, 3'b000, 3'b111, 4'd5, 1'b0);
    @(posedge Clk);
    #1;
    check({name, "_held"}, 3'b000, 3'b000, 3'b111, 4'd5, 1'b0);
    @(negedge Clk);
    reset_n = 1'b1;
  endtask

  // Reference model: integer elixir, frame count, armed/placing flags.
  bit       m_armed, m_placing;
  int       m_sel, m_elix, m_frames;
  bit [2:0] m_active;
  int       cost_tab[3] = '{3, 4, 5};

  task automatic model_reset;
    m_armed = 0; m_placing = 0; m_sel = 0; m_elix = 5; m_frames = 0; m_active = 3'b000;
  endtask

  task automatic model_step(input bit cv, input int cs, input bit ck, input int mx, input int my,
                            input bit [2:0] dd, input bit g, input bit tk,
                            output logic [2:0] e_in, output logic [2:0] e_dp, output logic [2:0] e_id,
                            output logic [3:0] e_el, output logic e_bz);
    bit       inwin, regen, spend, can_pick, go_place;
    int       old_elix;
    bit [2:0] old_act;
    inwin = (mx >= 200) && (mx <= 560) && (my >= 40) && (my <= 440);
    old_elix = m_elix;
    old_act = m_active;
    regen = 0; spend = 0; can_pick = 0; go_place = 0;
    if (cv && cs < 3) begin
      if (!old_act[cs] && old_elix >= cost_tab[cs]) can_pick = 1;
    end
    if (!g && tk) begin
      if (m_frames == 59) begin regen = 1; m_frames = 0; end
      else m_frames++;
    end
    if (m_placing && !g && old_elix >= cost_tab[m_sel]) spend = 1;
    e_id = g ? old_act : (old_act & dd);
    m_active = old_act & ~e_id;
    if (spend) m_active[m_sel] = 1'b1;
    m_elix = old_elix - (spend ? cost_tab[m_sel] : 0) + (regen ? 1 : 0);
    if (m_elix > 10) m_elix = 10;
    if (g || m_placing) m_armed = 0;
    else if (!m_armed) begin
      if (can_pick) begin m_armed = 1; m_sel = cs; end
    end
    else if (cv && cs == 3) m_armed = 0;
    else if (ck && inwin && old_elix >= cost_tab[m_sel]) begin m_armed = 0; go_place = 1; end
    else if (can_pick) m_sel = cs;
    m_placing = go_place;
    e_in = m_armed ? 3'(1 << m_sel) : 3'b000;
    e_dp = go_place ? 3'(1 << m_sel) : 3'b000;
    e_el = 4'(m_elix);
    e_bz = m_armed;
  endtask

  logic [2:0] r_in, r_dp, r_id, r_dd;
  logic [3:0] r_el;
  logic       r_bz, r_g, r_cv, r_ck, r_tk;
  logic [1:0] r_cs;
  int         r_mx, r_my;

  initial begin
    //          cv cs ck  mx   my   dd      instate deploy  idle    el bz
    tbl[0]  = '{0, 0, 0,   0,   0, 3'b000, 3'b000, 3'b000, 3'b000, 5, 0};
    tbl[1]  = '{1, 0, 0,   0,   0, 3'b000, 3'b001, 3'b000, 3'b000, 5, 1};
    tbl[2]  = '{0, 0, 0,   0,   0, 3'b000, 3'b001, 3'b000, 3'b000, 5, 1};
    tbl[3]  = '{0, 0, 1, 300, 200, 3'b000, 3'b000, 3'b001, 3'b000, 5, 0};
    tbl[4]  = '{0, 0, 0,   0,   0, 3'b000, 3'b000, 3'b000, 3'b000, 2, 0};
    tbl[5]  = '{1, 1, 0,   0,   0, 3'b000, 3'b000, 3'b000, 3'b000, 2, 0};
    tbl[6]  = '{1, 0, 0,   0,   0, 3'b000, 3'b000, 3'b000, 3'b000, 2, 0};
    tbl[7]  = '{1, 2, 0,   0,   0, 3'b000, 3'b000, 3'b000, 3'b000, 2, 0};
    tbl[8]  = '{1, 3, 1, 300, 200, 3'b000, 3'b000, 3'b000, 3'b000, 2, 0};
    tbl[9]  = '{0, 0, 0,   0,   0, 3'b001, 3'b000, 3'b000, 3'b001, 2, 0};
    tbl[10] = '{0, 0, 0,   0,   0, 3'b001, 3'b000, 3'b000, 3'b000, 2, 0};
    tbl[11] = '{1, 0, 0,   0,   0, 3'b000, 3'b000, 3'b000, 3'b000, 2, 0};

    do_reset("reset");
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].cv, tbl[i].cs, tbl[i].ck, tbl[i].mx, tbl[i].my, tbl[i].dd, 0, 0);
      step();
      check($sformatf("tbl%0d", i), tbl[i].e_in, tbl[i].e_dp, tbl[i].e_id, tbl[i].e_el, tbl[i].e_bz);
    end

    // Regen boundary: 59th tick must not add, 60th does.
    ticks(58);
    cyc("tick59",   0, 0, 0,   0,   0, 3'b000, 0, 1, 3'b000, 3'b000, 3'b000, 4'd2, 0);
    cyc("tick60",   0, 0, 0,   0,   0, 3'b000, 0, 1, 3'b000, 3'b000, 3'b000, 4'd3, 0);
    ticks(59);
    cyc("tick120",  0, 0, 0,   0,   0, 3'b000, 0, 1, 3'b000, 3'b000, 3'b000, 4'd4, 0);
    cyc("arm1",     1, 1, 0,   0,   0, 3'b000, 0, 0, 3'b010, 3'b000, 3'b000, 4'd4, 1);
    cyc("out_x_lo", 0, 0, 1, 100, 200, 3'b000, 0, 0, 3'b010, 3'b000, 3'b000, 4'd4, 1);
    cyc("out_x_hi", 0, 0, 1, 561, 200, 3'b000, 0, 0, 3'b010, 3'b000, 3'b000, 4'd4, 1);
    cyc("out_y_lo", 0, 0, 1, 300,  39, 3'b000, 0, 0, 3'b010, 3'b000, 3'b000, 4'd4, 1);
    cyc("out_y_hi", 0, 0, 1, 300, 441, 3'b000, 0, 0, 3'b010, 3'b000, 3'b000, 4'd4, 1);
    cyc("cancel",   1, 3, 1, 300, 200, 3'b000, 0, 0, 3'b000, 3'b000, 3'b000, 4'd4, 0);
    cyc("rearm1",   1, 1, 0,   0,   0, 3'b000, 0, 0, 3'b010, 3'b000, 3'b000, 4'd4, 1);
    cyc("place_mx", 0, 0, 1, 560, 440, 3'b000, 0, 0, 3'b000, 3'b010, 3'b000, 4'd4, 0);
    cyc("spent1",   0, 0, 0,   0,   0, 3'b000, 0, 0, 3'b000, 3'b000, 3'b000, 4'd0, 0);

    ticks(599);
    cyc("fill10",   0, 0, 0,   0,   0, 3'b000, 0, 1, 3'b000, 3'b000, 3'b000, 4'd10, 0);
    ticks(299);
    cyc("sat10",    0, 0, 0,   0,   0, 3'b000, 0, 1, 3'b000, 3'b000, 3'b000, 4'd10, 0);
    cyc("arm2",     1, 2, 0,   0,   0, 3'b000, 0, 0, 3'b100, 3'b000, 3'b000, 4'd10, 1);
    cyc("resel_bz", 1, 1, 0,   0,   0, 3'b000, 0, 0, 3'b100, 3'b000, 3'b000, 4'd10, 1);
    cyc("resel0",   1, 0, 0,   0,   0, 3'b000, 0, 0, 3'b001, 3'b000, 3'b000, 4'd10, 1);
    cyc("resel2",   1, 2, 0,   0,   0, 3'b000, 0, 0, 3'b100, 3'b000, 3'b000, 4'd10, 1);
    ticks(58);
    cyc("armtick",  0, 0, 0,   0,   0, 3'b000, 0, 1, 3'b100, 3'b000, 3'b000, 4'd10, 1);
    cyc("place2",   0, 0, 1, 300, 200, 3'b000, 0, 0, 3'b000, 3'b100, 3'b000, 4'd10, 0);
    cyc("spend_rg", 0, 0, 0,   0,   0, 3'b000, 0, 1, 3'b000, 3'b000, 3'b000, 4'd6, 0);
    cyc("arm0",     1, 0, 0,   0,   0, 3'b000, 0, 0, 3'b001, 3'b000, 3'b000, 4'd6, 1);
    cyc("place_mn", 0, 0, 1, 200,  40, 3'b000, 0, 0, 3'b000, 3'b001, 3'b000, 4'd6, 0);
    cyc("spent0",   0, 0, 0,   0,   0, 3'b000, 0, 0, 3'b000, 3'b000, 3'b000, 4'd3, 0);
    cyc("dead2",    0, 0, 0,   0,   0, 3'b100, 0, 0, 3'b000, 3'b000, 3'b100, 4'd3, 0);
    cyc("dead2_lv", 0, 0, 0,   0,   0, 3'b100, 0, 0, 3'b000, 3'b000, 3'b000, 4'd3, 0);
    ticks(119);
    cyc("to5",      0, 0, 0,   0,   0, 3'b000, 0, 1, 3'b000, 3'b000, 3'b000, 4'd5, 0);
    cyc("arm2b",    1, 2, 0,   0,   0, 3'b000, 0, 0, 3'b100, 3'b000, 3'b000, 4'd5, 1);
    cyc("gover",    1, 0, 1, 300, 200, 3'b000, 1, 1, 3'b000, 3'b000, 3'b011, 4'd5, 0);
    for (int i = 0; i < 100; i++)
      cyc("gover_hold", 1, 2'(i % 3), 1, 300, 200, 3'b111, 1, 1, 3'b000, 3'b000, 3'b000, 4'd5, 0);
    ticks(59);
    cyc("post_go",  0, 0, 0,   0,   0, 3'b000, 0, 1, 3'b000, 3'b000, 3'b000, 4'd6, 0);
    cyc("arm0b",    1, 0, 0,   0,   0, 3'b000, 0, 0, 3'b001, 3'b000, 3'b000, 4'd6, 1);
    do_reset("rst_armed");
    cyc("rst_rel",  0, 0, 0,   0,   0, 3'b000, 0, 0, 3'b000, 3'b000, 3'b000, 4'd5, 0);

    do_reset("rst_rand");
    model_reset();
    r_g = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!r_g) r_g = ($urandom_range(0, 63) == 0);
      else      r_g = ($urandom_range(0, 7) != 0);
      r_cv = ($urandom_range(0, 3) == 0);
      r_cs = 2'($urandom_range(0, 3));
      r_ck = ($urandom_range(0, 2) == 0);
      r_mx = $urandom_range(150, 620);
      r_my = $urandom_range(0, 480);
      r_dd = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      r_tk = ($urandom_range(0, 3) != 0);
      model_step(r_cv, int'(r_cs), r_ck, r_mx, r_my, r_dd, r_g, r_tk, r_in, r_dp, r_id, r_el, r_bz);
      cyc($sformatf("rand%0d", i), r_cv, r_cs, r_ck, r_mx, r_my, r_dd, r_g, r_tk,
          r_in, r_dp, r_id, r_el, r_bz);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
